lfsr_dr_sink: RTL and testbench

//  Clocked downstream consumer of the asynchronous lfsr_imp stage. Acts as the 4-phase

---
 rtl/lfsr_dr_sink_pkg.sv | 14 +
 rtl/lfsr_dr_sink_sync.sv | 34 +++
 rtl/lfsr_dr_sink.sv | 153 +++++++++++++++
 tb/tb_lfsr_dr_sink.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_dr_sink_pkg.sv
// Shared types for the dual-rail sink: handshake FSM states and counter width.
package lfsr_dr_sink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_CAPT = 3'd2,
    ST_FALL = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/lfsr_dr_sink_sync.sv
// N-bit multi-flop synchroniser; every bit passes STAGES flops, reset to zero.
module dr_sync_bus #(
  parameter int unsigned N      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage_q [STAGES];
  logic [N-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/lfsr_dr_sink.sv
// 4-phase RTZ master for lfsr_imp: synchronises dual-rail codewords, detects
// completion and conflicts, and buffers captured words in a valid/ready FIFO.
module lfsr_dr_sink
  import lfsr_dr_sink_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_err,
  output logic             req,
  input  logic             ack,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_code,
  output logic             err_tmo,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = 2 * WIDTH + 1;

  logic [SW-1:0]    sync_out;
  logic             s_ack;
  logic [WIDTH-1:0] s_d0, s_d1;

  dr_sync_bus #(.N(SW), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({ack, d0, d1}),
    .q     (sync_out)
  );

  assign {s_ack, s_d0, s_d1} = sync_out;

  logic complete, is_null, conflict;
  assign complete = &(s_d0 ^ s_d1);
  assign is_null  = ~|(s_d0 | s_d1);
  assign conflict = |(s_d0 & s_d1);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             stable_q, stable_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             err_code_q, err_code_d;
  logic             err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop;
  logic code_hit, tmo_hit, word_ok, timed_phase;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign timed_phase = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign code_hit    = ((state_q == ST_RISE) || (state_q == ST_CAPT)) && conflict;
  assign tmo_hit     = timed_phase && (timer_q == TW'(TIMEOUT - 1));
  // Word accepted only after two consecutive identical complete samples with ack.
  assign word_ok     = s_ack && complete && stable_q && (s_d1 == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable && !fifo_full && !s_ack && is_null) state_d = ST_RISE;
      ST_RISE: begin
        if (code_hit)     state_d = ST_ERR;
        else if (word_ok) state_d = ST_CAPT;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_CAPT: state_d = code_hit ? ST_ERR : ST_FALL;
      ST_FALL: begin
        if (tmo_hit)                 state_d = ST_ERR;
        else if (!s_ack && is_null)  state_d = ST_IDLE;
      end
      ST_ERR:  if (clr_err) state_d = ST_FALL;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d      = (state_d == ST_RISE) || (state_d == ST_CAPT);
    push       = (state_q == ST_CAPT) && !conflict;
    pop        = !fifo_empty && out_ready;
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d      = push ? cnt_q + 1'b1 : cnt_q;
    mem_d      = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = s_d1;
    err_code_d = code_hit ? 1'b1 : (clr_err ? 1'b0 : err_code_q);
    err_tmo_d  = tmo_hit  ? 1'b1 : (clr_err ? 1'b0 : err_tmo_q);
    stable_d   = (state_q == ST_RISE) && s_ack && complete;
    last_d     = s_d1;
    if (state_d != state_q) timer_d = '0;
    else if (timed_phase)   timer_d = timer_q + 1'b1;
    else                    timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      timer_q    <= '0;
      stable_q   <= 1'b0;
      last_q     <= '0;
      err_code_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      req_q      <= req_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      last_q     <= last_d;
      err_code_q <= err_code_d;
      err_tmo_q  <= err_tmo_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
    end
  end

  assign req       = req_q;
  assign out_valid = !fifo_empty;
  assign out_data  = mem_q[rd_q[AW-1:0]];
  assign err_code  = err_code_q;
  assign err_tmo   = err_tmo_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_dr_sink.sv
// Self-checking bench: behavioural lfsr_imp responder plus an in-order word scoreboard.
module tb_lfsr_dr_sink;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n, enable, clr_err, req, ack, out_valid, out_ready, err_code, err_tmo;
  logic [W-1:0] d0, d1, out_data;
  logic [15:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_dr_sink #(.WIDTH(W), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clr_err   (clr_err),
    .req       (req),
    .ack       (ack),
    .d0        (d0),
    .d1        (d1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_code  (err_code),
    .err_tmo   (err_tmo),
    .word_cnt  (word_cnt)
  );

  typedef enum int {M_NORMAL, M_CONFLICT, M_NOACK} imp_mode_e;
  imp_mode_e    imp_mode  = M_NORMAL;
  int           ack_delay = 3;
  bit           skew      = 1'b0;
  bit           rand_cw   = 1'b0;
  logic [W-1:0] fixed_cw  = 3'b101;
  logic [W-1:0] cur_cw;
  bit           hs_acked  = 1'b0;
  bit           hs_fault  = 1'b0;

  logic [W-1:0] exp_q [$];
  logic [15:0]  model_cnt = '0;
  bit           prev_req  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // lfsr_imp stand-in: rails then ack some cycles after req rises, null after req falls.
  initial begin
    ack = 1'b0; d0 = '0; d1 = '0;
    forever begin
      wait (req === 1'b1);
      hs_acked = 1'b0;
      hs_fault = 1'b0;
      cur_cw   = rand_cw ? W'($urandom) : fixed_cw;
      repeat (ack_delay) @(posedge clk);
      #1;
      if (imp_mode == M_NORMAL) begin
        d1 = cur_cw; d0 = ~cur_cw;
        if (skew) begin d1[0] = 1'b0; d0[0] = 1'b0; end
        ack = 1'b1; hs_acked = 1'b1;
        if (skew) begin
          @(posedge clk); #1;
          d1 = cur_cw; d0 = ~cur_cw;
        end
      end else if (imp_mode == M_CONFLICT) begin
        d1 = cur_cw; d0 = ~cur_cw;
        d1[2] = 1'b1; d0[2] = 1'b1;
        ack = 1'b1; hs_fault = 1'b1;
      end
      wait (req === 1'b0);
      repeat (ack_delay) @(posedge clk);
      #1;
      d0 = '0; d1 = '0; ack = 1'b0;
    end
  end

  // A clean handshake that ends with req dropping yields exactly one word, in order.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      model_cnt = '0;
      prev_req  = 1'b0;
    end else begin
      if (prev_req && req === 1'b0 && hs_acked && !hs_fault) begin
        exp_q.push_back(cur_cw);
        model_cnt++;
      end
      prev_req = (req === 1'b1);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("word_cnt", {16'd0, word_cnt}, {16'd0, model_cnt});
      if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
        check("out_data", {29'd0, out_data}, {29'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_req(input logic v, input int maxc, input string name);
    int n = 0;
    while (req !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, " req"}, {31'd0, req}, {31'd0, v});
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int maxc, input bit rnd, input string name);
    int n = 0;
    while (word_cnt !== target && n < maxc) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check({name, " word_cnt"}, {16'd0, word_cnt}, {16'd0, target});
  endtask

  task automatic wait_err(input bit tmo, input int maxc, output int n);
    n = 0;
    while ((tmo ? err_tmo : err_code) !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tmo ? "err_tmo set" : "err_code set", {31'd0, tmo ? err_tmo : err_code}, 32'd1);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    while (!(req === 1'b0 && ack === 1'b0 && d0 === '0 && d1 === '0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, " quiesce"}, {31'd0, n < maxc}, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_clr;
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  task automatic one_handshake(input logic [15:0] target, input bit rnd, input string name);
    @(posedge clk); #1 enable = 1'b1;
    wait_req(1'b1, 40, name);
    enable = 1'b0;
    wait_cnt(target, 200, rnd, name);
    wait_idle(200, name);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req",      {31'd0, req},       32'd0);
    check("rst out_valid",{31'd0, out_valid}, 32'd0);
    check("rst out_data", {29'd0, out_data},  32'd0);
    check("rst err_code", {31'd0, err_code},  32'd0);
    check("rst err_tmo",  {31'd0, err_tmo},   32'd0);
    check("rst word_cnt", {16'd0, word_cnt},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single fixed codeword a1,b0,c1
    one_handshake(16'd1, 1'b0, "t1");
    check("t1 out_data", {29'd0, out_data}, 32'h5);
    check("t1 word_cnt", {16'd0, word_cnt}, 32'd1);
    check("t1 req",      {31'd0, req},      32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("t1 popped", {31'd0, out_valid}, 32'd0);

    // 2: back-pressure fills the FIFO, then drain and two more words
    rand_cw = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_cnt(16'd5, 400, 1'b0, "t2 fill");
    repeat (40) @(negedge clk);
    check("t2 full word_cnt", {16'd0, word_cnt}, 32'd5);
    check("t2 full req",      {31'd0, req},      32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_cnt(16'd6, 200, 1'b0, "t2 resume");
    wait_req(1'b1, 40, "t2 seventh");
    enable = 1'b0;
    wait_cnt(16'd7, 200, 1'b0, "t2 last");
    wait_idle(200, "t2");
    check("t2 final word_cnt", {16'd0, word_cnt}, 32'd7);
    check("t2 drained",        {31'd0, out_valid}, 32'd0);

    // 3: rail conflict
    imp_mode = M_CONFLICT;
    @(posedge clk); #1 enable = 1'b1;
    wait_req(1'b1, 40, "t3");
    enable = 1'b0;
    wait_err(1'b0, 60, n);
    repeat (10) @(negedge clk);
    check("t3 err_code held", {31'd0, err_code}, 32'd1);
    check("t3 req low",       {31'd0, req},      32'd0);
    check("t3 no push",       {16'd0, word_cnt}, 32'd7);
    imp_mode = M_NORMAL;
    pulse_clr();
    @(negedge clk);
    check("t3 err_code cleared", {31'd0, err_code}, 32'd0);
    wait_idle(100, "t3");
    one_handshake(16'd8, 1'b0, "t3 recover");

    // 4: ack never arrives
    imp_mode = M_NOACK;
    @(posedge clk); #1 enable = 1'b1;
    wait_req(1'b1, 40, "t4");
    enable = 1'b0;
    wait_err(1'b1, 300, n);
    check("t4 timeout latency", {31'd0, (n >= 250 && n <= 262)}, 32'd1);
    @(negedge clk);
    check("t4 req low", {31'd0, req}, 32'd0);
    imp_mode = M_NORMAL;
    pulse_clr();
    @(negedge clk);
    check("t4 err_tmo cleared", {31'd0, err_tmo}, 32'd0);
    wait_idle(100, "t4");
    one_handshake(16'd9, 1'b0, "t4 recover");

    // 5: reset in the middle of RISE with a word buffered
    out_ready = 1'b0;
    one_handshake(16'd10, 1'b0, "t5 buffer");
    ack_delay = 6;
    @(posedge clk); #1 enable = 1'b1;
    wait_req(1'b1, 40, "t5");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("t5 rst req",       {31'd0, req},       32'd0);
    check("t5 rst out_valid", {31'd0, out_valid}, 32'd0);
    check("t5 rst word_cnt",  {16'd0, word_cnt},  32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    wait_idle(100, "t5");
    ack_delay = 3;
    one_handshake(16'd1, 1'b0, "t5 restart");
    check("t5 restart word_cnt", {16'd0, word_cnt}, 32'd1);

    // 6: random codewords, random ack delay and c-late skew, random back-pressure
    for (int i = 0; i < 24; i++) begin
      ack_delay = $urandom_range(1, 5);
      skew      = 1'($urandom);
      one_handshake(16'(i + 2), 1'b1, "t6");
    end
    skew = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("final drained", {31'd0, out_valid}, 32'd0);
    check("final word_cnt", {16'd0, word_cnt}, 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
